// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM encoding and helpers for the binary-to-BCD converter
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Decimal capacity of n digits, used to reject undersized DIGITS at elaboration.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: adds 3 to a BCD digit of 5 or more
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter with valid/ready on both sides
// Optional two's-complement input handling is enabled by defining BIN2BCD_SIGNED_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [W-1:0]          IN_BIN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [4*DIGITS-1:0]   OUT_BCD,
  output logic                  OUT_NEG,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [63:0] MAX_BIN = (64'd1 << W) - 64'd1;
  localparam logic [63:0] DEC_CAP = pow10(DIGITS);

  generate
    if (DEC_CAP <= MAX_BIN) begin : g_size_check
      $error("bin2bcd_seq: DIGITS too small for W");
    end
  endgenerate

  bcd_state_t r_state;
  bcd_state_t w_next_state;

  logic [W-1:0]     r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_out_bcd;
  logic             r_out_valid;
  logic             w_in_ready;

  logic [BCD_W-1:0] w_bcd_adj;
  logic [BCD_W-1:0] w_bcd_shift;
  logic [W-1:0]     w_bin_shift;
  logic             w_unused_msb;
  logic             w_last;
  logic [W-1:0]     w_load;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The bit shifted out of the top digit is always 0 once DIGITS is large enough.
  assign {w_unused_msb, w_bcd_shift, w_bin_shift} = {w_bcd_adj, r_bin, 1'b0};
  assign w_last = (r_cnt == CNT_W'(1));

`ifdef BIN2BCD_SIGNED_EN
  logic r_neg_pend;
  logic r_out_neg;
  assign w_load  = IN_BIN[W-1] ? (~IN_BIN + W'(1)) : IN_BIN;
  assign OUT_NEG = r_out_neg;
`else
  assign w_load  = IN_BIN;
  assign OUT_NEG = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (IN_VALID)  w_next_state = SHIFT;
      SHIFT:   if (w_last)    w_next_state = DONE;
      DONE:    if (OUT_READY) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    if (!RST && (r_state == IDLE)) begin
      w_in_ready = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_out_bcd   <= '0;
      r_out_valid <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      r_neg_pend  <= 1'b0;
      r_out_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_bin <= w_load;
            r_bcd <= '0;
            r_cnt <= CNT_W'(W);
`ifdef BIN2BCD_SIGNED_EN
            r_neg_pend <= IN_BIN[W-1];
`endif
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_shift;
          r_bin <= w_bin_shift;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_out_bcd   <= w_bcd_shift;
            r_out_valid <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
            r_out_neg   <= r_neg_pend;
`endif
          end
        end
        DONE: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_BCD   = r_out_bcd;
  assign OUT_VALID = r_out_valid;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized and directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  localparam int W = 8;
  localparam int DIGITS = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [W-1:0] IN_BIN;
  logic        IN_VALID;
  logic        IN_READY;
  logic [11:0] OUT_BCD;
  logic        OUT_NEG;
  logic        OUT_VALID;
  logic        OUT_READY;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 CLK = ~CLK;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_BIN    (IN_BIN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_BCD   (OUT_BCD),
    .OUT_NEG   (OUT_NEG),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference conversion by decimal arithmetic.
  function automatic logic [11:0] ref_bcd(input logic [W-1:0] v);
    int mag;
    mag = int'(v);
`ifdef BIN2BCD_SIGNED_EN
    if (v[W-1]) mag = 256 - int'(v);
`endif
    return {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  function automatic logic ref_neg(input logic [W-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    return v[W-1];
`else
    return 1'b0 & v[0];
`endif
  endfunction

  // Transaction-level timing model: accept, W cycles busy, hold until taken.
  int          m_mode = 0;
  int          m_cnt  = 0;
  bit          m_live = 0;
  logic        m_valid = 1'b0;
  logic [11:0] m_bcd = '0;
  logic        m_neg = 1'b0;
  logic [11:0] m_pend_bcd;
  logic        m_pend_neg;
  int          cyc = 0;
  int          acc_q[$];

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      m_live = 1; m_mode = 0; m_valid = 0; m_bcd = '0; m_neg = 0;
    end else if (m_mode == 0) begin
      if (IN_VALID) begin
        m_pend_bcd = ref_bcd(IN_BIN);
        m_pend_neg = ref_neg(IN_BIN);
        m_cnt = W; m_mode = 1;
        acc_q.push_back(cyc);
      end
    end else if (m_mode == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1; m_bcd = m_pend_bcd; m_neg = m_pend_neg; m_mode = 2;
      end
    end else begin
      if (OUT_READY) begin
        m_valid = 0; m_mode = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      chk("in_ready", IN_READY, (m_mode == 0) && !RST);
      chk("out_valid", OUT_VALID, m_valid);
      if (m_valid) begin
        chk("out_bcd", OUT_BCD, m_bcd);
        chk("out_neg", OUT_NEG, m_neg);
        for (int d = 0; d < DIGITS; d++)
          chk("digit_le9", OUT_BCD[d*4 +: 4] <= 4'd9, 1'b1);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!IN_READY && t < 100) begin
      @(posedge CLK); #1; t++;
    end
    if (t >= 100) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] v, input logic [11:0] exp_bcd, input logic exp_neg, input int stall);
    int lat = 0;
    wait_ready();
    IN_BIN = v; IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(posedge CLK); #1 IN_VALID = 1'b0;
    do begin
      @(posedge CLK); #1; lat++;
    end while (!OUT_VALID && lat < 50);
    chk("latency", lat, W);
    chk("lit_bcd", OUT_BCD, exp_bcd);
    chk("lit_neg", OUT_NEG, exp_neg);
    repeat (stall) begin @(posedge CLK); #1; end
    chk("stall_bcd", OUT_BCD, exp_bcd);
    chk("stall_valid", OUT_VALID, 1'b1);
    OUT_READY = 1'b1;
    @(posedge CLK); #1 OUT_READY = 1'b0;
    chk("handshake_clear", OUT_VALID, 1'b0);
  endtask

  initial begin
    int base;
    int t;
    logic [11:0] got[$];
    logic [W-1:0] vals[256];

    RST = 1'b1; IN_BIN = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    chk("rst_valid", OUT_VALID, 1'b0);
    chk("rst_bcd", OUT_BCD, 12'h000);
    chk("rst_neg", OUT_NEG, 1'b0);
    chk("rst_in_ready", IN_READY, 1'b0);
    @(posedge CLK); #1 RST = 1'b0;

    chk("model_255", ref_bcd(8'd255), 12'h255);
    chk("model_99", ref_bcd(8'd99), 12'h099);
    chk("model_0", ref_bcd(8'd0), 12'h000);

`ifdef BIN2BCD_SIGNED_EN
    run_op(8'h80, 12'h128, 1'b1, 0);
    run_op(8'hFF, 12'h001, 1'b1, 0);
    run_op(8'd127, 12'h127, 1'b0, 0);
    run_op(8'd137, 12'h119, 1'b1, 20);
`else
    run_op(8'd255, 12'h255, 1'b0, 0);
    run_op(8'd137, 12'h137, 1'b0, 20);
`endif

    // Back-to-back with IN_VALID held; second accept must wait for the handshake.
    wait_ready();
    base = acc_q.size();
    OUT_READY = 1'b1; IN_BIN = 8'd0; IN_VALID = 1'b1;
    t = 0;
    while (t < 40) begin
      @(posedge CLK); #1; t++;
      if (OUT_VALID) got.push_back(OUT_BCD);
      if (acc_q.size() == base + 1) IN_BIN = 8'd99;
      if (acc_q.size() == base + 2) IN_VALID = 1'b0;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    chk("b2b_accepts", acc_q.size() - base, 2);
    chk("b2b_outputs", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_first", got[0], 12'h000);
      chk("b2b_second", got[1], 12'h099);
    end
    if (acc_q.size() >= base + 2)
      chk("b2b_interval", acc_q[base+1] - acc_q[base], W + 2);

    // Reset during the fourth SHIFT cycle discards the operation.
    wait_ready();
    IN_BIN = 8'd200; IN_VALID = 1'b1;
    @(posedge CLK); #1 IN_VALID = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort_valid", OUT_VALID, 1'b0);
    chk("abort_bcd", OUT_BCD, 12'h000);
    chk("abort_in_ready", IN_READY, 1'b0);
    RST = 1'b0;
    run_op(8'd42, 12'h042, 1'b0, 0);

    // Randomized sweep of every input value in shuffled order.
    for (int i = 0; i < 256; i++) vals[i] = W'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [W-1:0] tmp;
      j = $urandom_range(i, 0);
      tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(2, 0)) begin
        IN_BIN = W'($urandom); OUT_READY = 1'($urandom);
        @(posedge CLK); #1;
      end
      base = acc_q.size();
      IN_BIN = vals[i]; IN_VALID = 1'b1;
      t = 0;
      while (acc_q.size() == base && t < 60) begin
        OUT_READY = 1'($urandom);
        @(posedge CLK); #1; t++;
      end
      if (t >= 60) chk("sweep_accept_timeout", 0, 1);
      IN_VALID = 1'b0;
      t = 0;
      while (m_mode != 0 && t < 60) begin
        IN_BIN = W'($urandom);
        OUT_READY = 1'($urandom);
        @(posedge CLK); #1; t++;
      end
      if (t >= 60) chk("sweep_done_timeout", 0, 1);
    end
    OUT_READY = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the BCD adder: converts W-bit binary operands into packed BCD digits, which feed the adder's 8-bit two-digit BCD inputs.
- Has a valid/ready handshake on both input and output, so converted operands can be queued into the adder path.

Parameters:
- W, 8, binary input width.
- DIGITS, 3, number of BCD output digits. Requirement: 10^DIGITS > 2^W − 1; the RTL checks this at elaboration time.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_BIN  input  W  binary operand.
- IN_VALID  input  1  IN_BIN is valid.
- IN_READY  output  1  converter can accept an operand.
- OUT_BCD  output  4*DIGITS  packed BCD result; digit 0 (ones) is in [3:0].
- OUT_NEG  output  1  sign of the result; see Optional Feature.
- OUT_VALID  output  1  OUT_BCD/OUT_NEG are valid.
- OUT_READY  input  1  downstream consumes the result.

Behaviour:
- Reset: one clock, synchronous reset, active-high.
  - RST sampled high on an edge forces state to IDLE.
  - Clears OUT_BCD=0, OUT_NEG=0, OUT_VALID=0, shift register=0, bit counter=0.
  - While RST is high, IN_READY=0.
  - Reset mid-conversion or in DONE aborts the operation; the result is discarded and never presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY=1.
  - On an edge with IN_VALID=1, the operand is accepted: load binary shift register with IN_BIN, clear BCD register, counter=W, go to SHIFT.
- SHIFT:
  - IN_READY=0.
  - Each edge: every 4-bit digit ≥5 gets +3 (combinational adjust, all digits in parallel), then {BCD, BIN} shifts left by 1 and counter decrements.
  - The edge on which the counter reaches 0 transfers the BCD register to OUT_BCD, sets OUT_VALID=1 and goes to DONE.
- DONE:
  - OUT_VALID=1 and OUT_BCD/OUT_NEG are held stable until OUT_READY=1.
  - On the edge with OUT_READY=1: OUT_VALID=0, go to IDLE.
  - IN_READY=0 in DONE; there is no overlap of a new accept with the pending result.
- Latency: OUT_VALID is first high W cycles after the accept cycle.
- Minimum initiation interval: W+2 cycles.
- Arithmetic:
  - Adjust compares the 4-bit digit unsigned against 5; the +3 is a 4-bit add and never overflows for a digit ≤9.
  - Each output digit is always 0–9.
  - Upper digits not reached by the value are 0.
- Boundaries:
  - IN_BIN=0 gives all-zero BCD.
  - IN_BIN=2^W−1 must fit DIGITS.
  - IN_VALID while IN_READY=0 is ignored; the source must hold it.
  - OUT_READY while OUT_VALID=0 has no effect.

Optional Feature:
- Macro BIN2BCD_SIGNED_EN.
- Defined:
  - IN_BIN is two's complement.
  - At accept, OUT_NEG's pending flag = IN_BIN[W-1].
  - The shift register loads the magnitude (−IN_BIN, W bits, interpreted unsigned), so −2^(W−1) converts to magnitude 2^(W−1).
  - OUT_NEG updates together with OUT_BCD.
- Undefined:
  - IN_BIN is unsigned.
  - OUT_NEG is tied 0.
  - No negation logic is synthesised.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4;
  - ADJ_THRESH=4'd5;
  - ADJ_ADD=4'd3;
  - the FSM state encoding (IDLE, SHIFT, DONE) used by the converter.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, +3 when ≥5. The converter instantiates DIGITS copies.

Test Plan:
- IN_BIN=8'd255, OUT_READY=1 → OUT_VALID 8 cycles after accept, OUT_BCD=12'h255, OUT_NEG=0.
- IN_BIN=0 and then IN_BIN=99 back-to-back with IN_VALID held → OUT_BCD=12'h000, then 12'h099. Second accept occurs only after the first output handshake; interval = 10 cycles.
- IN_BIN=8'd137, OUT_READY=0 for 20 cycles then 1 → OUT_BCD=12'h137 stable and OUT_VALID=1 throughout the stall; IN_READY=0 until one cycle after the handshake.
- IN_BIN=8'd200 accepted, RST=1 at 4th SHIFT cycle → next cycle IDLE, OUT_VALID=0, OUT_BCD=0; a following IN_BIN=8'd42 yields 12'h042.
- With BIN2BCD_SIGNED_EN:
  - IN_BIN=8'h80 → OUT_BCD=12'h128, OUT_NEG=1;
  - IN_BIN=8'hFF → 12'h001, OUT_NEG=1;
  - IN_BIN=8'd127 → 12'h127, OUT_NEG=0.
- Random sweep of all 256 unsigned values versus a reference model → every digit ≤9 and exact match.
